light_mode_controller: RTL and testbench
========================================

# light_mode_controller

Sequences the LED output modes of the light board from debounced button events. It sits directly downstream of the per-button debouncers, which deliver one-cycle release pulses. It edge-detects and prioritises the power and mode events, runs the mode state machine, and generates the LED pattern for each mode (steady, PWM dim, blink, chase). It also exposes the current mode for status display.

## Interface
- LED_W, 8: number of LED outputs driven (min 2)
- BLINK_HALF, 50_000_000: cycles per blink half-period and per chase step (0.5 s at 100 MHz); min 1
- PWM_PERIOD, 100_000: PWM period in cycles for DIM mode (1 kHz at 100 MHz); min 1
- DIM_HIGH, 25_000: cycles per PWM period that LEDs are on in DIM; 0 = never on, >= PWM_PERIOD = always on
- i_clk  in  1  system clock; all logic on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_btn_power  in  1  debounced power event pulse
- i_btn_mode  in  1  debounced mode-advance event pulse
- o_led  out  LED_W  LED drive pattern, registered
- o_state  out  3  current mode code, registered

## Operation
- Event detection:
  - Each button input is registered.
  - event = input high this cycle AND previous sample low.
  - A pulse held high N cycles produces exactly one event.
  - Previous-sample registers reset to 0, so an input already high when reset releases yields one event.
- Mode codes: OFF=0, ON=1, DIM=2, BLINK=3, CHASE=4. Codes 5–7 are unreachable; if entered, go to OFF next cycle.
- Transitions:
  - OFF + power → ON.
  - OFF + mode → ignored.
  - Any non-OFF mode + power → OFF.
  - Mode cycles ON→DIM→BLINK→CHASE→ON.
  - Power and mode events in the same cycle: power wins; the mode event is discarded, not queued.
- Mode timer:
  - Counts 0..BLINK_HALF-1 and wraps.
  - The cycle where count = BLINK_HALF-1 is a "tick".
- PWM counter: counts 0..PWM_PERIOD-1 and wraps.
- On every state change, both counters clear to 0, the blink phase sets to 1, and the chase position sets to bit 0.
- LED patterns:
  - OFF: all 0.
  - ON: all 1.
  - DIM: all 1 while pwm_count < DIM_HIGH, else all 0.
  - BLINK: all 1 while phase = 1, all 0 otherwise; phase toggles on each tick.
  - CHASE: one-hot at the chase position; rotates left by one on each tick; MSB wraps to bit 0.
- Counters freeze at 0 in OFF and ON.
- Counter widths are sized by $clog2 of the parameter values; no overflow past the wrap point.

## Timing
- Reset (asynchronous, immediate, including mid-operation): o_state=0, o_led=0, all counters 0, phase 1, chase position 0, previous samples 0.
- Button pulse sampled high at edge k (first high sample) → o_state holds the new code after edge k.
- o_led shows the first pattern of the new mode after edge k+1. Total pulse-to-LED latency is 2 cycles.
- In BLINK, o_led is all-1 for exactly BLINK_HALF cycles starting after edge k+1, then alternates every BLINK_HALF cycles.
- In CHASE, each position holds exactly BLINK_HALF cycles.
- In DIM, o_led is high for exactly DIM_HIGH cycles of every PWM_PERIOD cycles.
- A new event arriving during the 1-cycle o_led lag is processed normally. o_led always follows o_state by one cycle.

## Test plan
All scenarios use sim parameters LED_W=4, BLINK_HALF=4, PWM_PERIOD=8, DIM_HIGH=2.
- Power-on: release reset, power pulse at cycle 10 → o_state=1 after that edge; o_led=4'hF one cycle later; o_led=0 before.
- Mode cycling: from ON, 4 mode pulses 20 cycles apart → o_state goes 2,3,4,1. In DIM, o_led=4'hF for 2 of every 8 cycles, starting on the first LED cycle.
- Blink/chase timing:
  - BLINK: o_led goes F×4, 0×4, F×4.
  - CHASE: o_led goes 1,2,4,8,1, each held 4 cycles.
  - Re-entering a mode restarts its pattern at F or 1.
- Priority and filtering:
  - Power and mode pulses in the same cycle while in BLINK → o_state=0, o_led=0; no later mode change.
  - Mode pulse in OFF → o_state stays 0.
  - Power held high for 5 cycles → exactly one transition.
- Reset mid-CHASE: assert i_reset_n=0 between clock edges → o_state and o_led become 0 without waiting for a clock edge.
- Input already high at reset release: power held high through the release of reset → one event; o_state=1.

Source files
------------

// File: rtl/light_mode_controller.sv
// Purpose : light board mode sequencer; turns debounced power/mode button pulses into an LED pattern.
// Latency : button event -> o_state after 1 edge, o_led after 2 edges (o_led trails o_state by one cycle).
// Backpressure: none; every rising input edge is consumed immediately and simultaneous mode events lose to power.
// Ports   : i_clk/i_reset_n (async active-low), i_btn_power/i_btn_mode event pulses,
//           o_led (registered LED pattern, LED_W bits), o_state (registered mode code, 3 bits).
module light_mode_controller #(
  parameter int LED_W      = 8,
  parameter int BLINK_HALF = 50_000_000,
  parameter int PWM_PERIOD = 100_000,
  parameter int DIM_HIGH   = 25_000
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_btn_power,
  input  logic             i_btn_mode,
  output logic [LED_W-1:0] o_led,
  output logic [2:0]       o_state
);

  localparam logic [2:0] S_OFF   = 3'd0;
  localparam logic [2:0] S_ON    = 3'd1;
  localparam logic [2:0] S_DIM   = 3'd2;
  localparam logic [2:0] S_BLINK = 3'd3;
  localparam logic [2:0] S_CHASE = 3'd4;

  // A period of 1 would give a zero-width counter; keep at least one bit.
  localparam int TW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam logic [TW-1:0] TMR_MAX = TW'(BLINK_HALF - 1);
  localparam logic [PW-1:0] PWM_MAX = PW'(PWM_PERIOD - 1);

  logic             pwr_prev_q, pwr_prev_d;
  logic             mode_prev_q, mode_prev_d;
  logic [2:0]       state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [PW-1:0]    pwm_q, pwm_d;
  logic             phase_q, phase_d;
  logic [LED_W-1:0] chase_q, chase_d;
  logic [LED_W-1:0] led_q, led_d;

  logic pwr_evt, mode_evt, tick;

  // Rising-edge detect: a pulse held high for many cycles still counts once.
  assign pwr_evt     = i_btn_power & ~pwr_prev_q;
  assign mode_evt    = i_btn_mode  & ~mode_prev_q;
  assign pwr_prev_d  = i_btn_power;
  assign mode_prev_d = i_btn_mode;
  assign tick        = (tmr_q == TMR_MAX);

  // State register (plus counters and edge-detect history).
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pwr_prev_q  <= 1'b0;
      mode_prev_q <= 1'b0;
      state_q     <= S_OFF;
      tmr_q       <= '0;
      pwm_q       <= '0;
      phase_q     <= 1'b1;
      chase_q     <= LED_W'(1);
      led_q       <= '0;
    end else begin
      pwr_prev_q  <= pwr_prev_d;
      mode_prev_q <= mode_prev_d;
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      pwm_q       <= pwm_d;
      phase_q     <= phase_d;
      chase_q     <= chase_d;
      led_q       <= led_d;
    end
  end

  // Next-state logic. Power is checked first so a coincident mode event is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:   if (pwr_evt) state_d = S_ON;
      S_ON:    if (pwr_evt) state_d = S_OFF; else if (mode_evt) state_d = S_DIM;
      S_DIM:   if (pwr_evt) state_d = S_OFF; else if (mode_evt) state_d = S_BLINK;
      S_BLINK: if (pwr_evt) state_d = S_OFF; else if (mode_evt) state_d = S_CHASE;
      S_CHASE: if (pwr_evt) state_d = S_OFF; else if (mode_evt) state_d = S_ON;
      default: state_d = S_OFF;
    endcase
  end

  // Timers and pattern generators. Any mode change restarts every pattern from
  // its first step so a re-entered mode always looks the same.
  always_comb begin
    tmr_d   = tmr_q;
    pwm_d   = pwm_q;
    phase_d = phase_q;
    chase_d = chase_q;
    if (state_d != state_q) begin
      tmr_d   = '0;
      pwm_d   = '0;
      phase_d = 1'b1;
      chase_d = LED_W'(1);
    end else if (state_q == S_DIM || state_q == S_BLINK || state_q == S_CHASE) begin
      tmr_d = tick ? '0 : tmr_q + 1'b1;
      pwm_d = (pwm_q == PWM_MAX) ? '0 : pwm_q + 1'b1;
      if (tick) begin
        phase_d = ~phase_q;
        chase_d = {chase_q[LED_W-2:0], chase_q[LED_W-1]};
      end
    end else begin
      tmr_d = '0;
      pwm_d = '0;
    end
  end

  // Output logic: pattern for the current (already registered) mode, registered
  // once more so o_led trails o_state by exactly one cycle.
  always_comb begin
    led_d = '0;
    case (state_q)
      S_ON:    led_d = '1;
      S_DIM:   led_d = (int'(pwm_q) < DIM_HIGH) ? '1 : '0;
      S_BLINK: led_d = phase_q ? '1 : '0;
      S_CHASE: led_d = chase_q;
      default: led_d = '0;
    endcase
  end

  assign o_led   = led_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_light_mode_controller.sv
// Purpose : directed self-checking bench for light_mode_controller at LED_W=4, BLINK_HALF=4, PWM_PERIOD=8, DIM_HIGH=2.
// Latency : inputs driven and outputs sampled on the falling clock edge.
// Backpressure: not applicable.
module tb_light_mode_controller;

  logic       clk;
  logic       rst_n;
  logic       btn_power;
  logic       btn_mode;
  logic [3:0] led;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  light_mode_controller #(
    .LED_W(4), .BLINK_HALF(4), .PWM_PERIOD(8), .DIM_HIGH(2)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_btn_power(btn_power),
    .i_btn_mode (btn_mode),
    .o_led      (led),
    .o_state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One low cycle first so back-to-back calls still present a fresh rising edge,
  // then one high cycle. Returns at the falling edge right after the sampling edge.
  task automatic pulse(input logic pwr, input logic mode);
    @(negedge clk);
    btn_power = pwr;
    btn_mode  = mode;
    @(negedge clk);
    btn_power = 1'b0;
    btn_mode  = 1'b0;
  endtask

  task automatic mode_to(input logic [2:0] exp_state, input string tag);
    pulse(1'b0, 1'b1);
    chk(tag, 32'(state), 32'(exp_state));
  endtask

  initial begin
    logic [3:0] exp_led;
    btn_power = 1'b0;
    btn_mode  = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_led",   32'(led),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle in OFF until the power press.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("off_led_%0d", i), 32'(led), 32'd0);
    end

    // Power-on: state after the sampling edge, LEDs one cycle later.
    pulse(1'b1, 1'b0);
    chk("pwr_on_state", 32'(state), 32'd1);
    chk("pwr_on_led_lag", 32'(led), 32'd0);
    @(negedge clk);
    chk("pwr_on_led", 32'(led), 32'hF);
    repeat (18) @(negedge clk);

    // DIM: on for 2 of every 8 cycles, starting on the first LED cycle.
    mode_to(3'd2, "to_dim");
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_led = ((i % 8) < 2) ? 4'hF : 4'h0;
      chk($sformatf("dim_%0d", i), 32'(led), 32'(exp_led));
    end

    // BLINK: F x4, 0 x4, F x4; leaves with the phase low.
    mode_to(3'd3, "to_blink");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      exp_led = (((i / 4) % 2) == 0) ? 4'hF : 4'h0;
      chk($sformatf("blink_%0d", i), 32'(led), 32'(exp_led));
    end

    // CHASE: 1,2,4,8,1 each held 4 cycles; leaves at position 1.
    mode_to(3'd4, "to_chase");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      exp_led = 4'd1 << ((i / 4) % 4);
      chk($sformatf("chase_%0d", i), 32'(led), 32'(exp_led));
    end

    mode_to(3'd1, "to_on");
    @(negedge clk);
    chk("on_led", 32'(led), 32'hF);

    // Re-entry restarts BLINK at F and CHASE at bit 0.
    mode_to(3'd2, "re_dim");
    mode_to(3'd3, "re_blink");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_led = (i < 4) ? 4'hF : 4'h0;
      chk($sformatf("reblink_%0d", i), 32'(led), 32'(exp_led));
    end
    mode_to(3'd4, "re_chase");
    @(negedge clk);
    chk("rechase_first", 32'(led), 32'h1);

    // Power and mode together in BLINK: power wins, mode is not queued.
    mode_to(3'd1, "p_on");
    mode_to(3'd2, "p_dim");
    mode_to(3'd3, "p_blink");
    pulse(1'b1, 1'b1);
    chk("prio_state", 32'(state), 32'd0);
    @(negedge clk);
    chk("prio_led", 32'(led), 32'd0);
    repeat (8) @(negedge clk);
    chk("prio_no_queue", 32'(state), 32'd0);

    // Mode press while OFF is ignored.
    pulse(1'b0, 1'b1);
    chk("off_mode_ignored", 32'(state), 32'd0);
    repeat (3) @(negedge clk);
    chk("off_mode_led", 32'(led), 32'd0);

    // Power held for 5 cycles: exactly one transition.
    @(negedge clk);
    btn_power = 1'b1;
    @(negedge clk);
    chk("hold_first", 32'(state), 32'd1);
    repeat (4) @(negedge clk);
    chk("hold_mid", 32'(state), 32'd1);
    btn_power = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_after", 32'(state), 32'd1);

    // Into CHASE, then reset between clock edges.
    mode_to(3'd2, "r_dim");
    mode_to(3'd3, "r_blink");
    mode_to(3'd4, "r_chase");
    repeat (6) @(negedge clk);
    chk("r_chase_led", 32'(led), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_led",   32'(led),   32'd0);

    // Power held high across reset release gives one event.
    btn_power = 1'b1;
    repeat (2) @(negedge clk);
    chk("in_rst_state", 32'(state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_state", 32'(state), 32'd1);
    repeat (3) @(negedge clk);
    chk("rel_held_state", 32'(state), 32'd1);
    btn_power = 1'b0;
    @(negedge clk);
    chk("rel_led", 32'(led), 32'hF);
    chk("rel_final_state", 32'(state), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
